// File: rtl/mips_trace_capture_pkg.sv
// Shared types and constants for the mips_32 retire-trace capture block.
package mips_trace_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      HDR  = 3'd1,
      PCW  = 3'd2,
      INSW = 3'd3,
      ALUW = 3'd4
   } drainState_t;

   // Bit positions inside the flags byte
   localparam int FLAG_REGWRTE   = 0;
   localparam int FLAG_MEMWRITE  = 1;
   localparam int FLAG_MEMREAD   = 2;
   localparam int FLAG_BRANCH    = 3;
   localparam int FLAG_BEQ       = 4;
   localparam int FLAG_JUMP      = 5;
   localparam int FLAG_MEMTOREG  = 6;
   localparam int FLAG_ALUSOURCE = 7;

   localparam int          BEAT_COUNT        = 4;
   localparam logic [7:0]  DEFAULT_SYNC_WORD = 8'hA5;

   typedef struct packed {
      logic [15:0] seq;
      logic [7:0]  flags;
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] alu;
   } traceRecord_t;

endpackage

// File: rtl/mips_trace_capture_if.sv
// Observation-port inputs plus trace stream outputs of the capture block.
interface mips_trace_capture_if #(parameter int DEPTH = 8);
   logic                     trace_en;
   logic [31:0]              PC;
   logic [31:0]              Instruction;
   logic [31:0]              ALU_Result;
   logic                     RegWrte, MemWrite, MemRead, Branch, Beq, Jump, MemtoReg, AluSource;
   logic [31:0]              out_data;
   logic                     out_valid;
   logic                     out_ready;
   logic                     out_last;
   logic [15:0]              drop_count;
   logic [$clog2(DEPTH):0]   fifo_level;

   modport master (
      output trace_en, PC, Instruction, ALU_Result,
             RegWrte, MemWrite, MemRead, Branch, Beq, Jump, MemtoReg, AluSource,
             out_ready,
      input  out_data, out_valid, out_last, drop_count, fifo_level
   );

   modport slave (
      input  trace_en, PC, Instruction, ALU_Result,
             RegWrte, MemWrite, MemRead, Branch, Beq, Jump, MemtoReg, AluSource,
             out_ready,
      output out_data, out_valid, out_last, drop_count, fifo_level
   );
endinterface

// File: rtl/mips_trace_capture_fifo.sv
// Single-clock record FIFO; a push into a full FIFO is accepted when a pop happens the same cycle.
module trace_fifo #(
   parameter int WIDTH = 120,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FullLevel = DEPTH[AW:0];

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wrPtr, rdPtr;
   logic [AW:0]      count;
   logic             doPush, doPop;

   assign empty  = (count == '0);
   assign full   = (count == FullLevel);
   assign doPop  = pop && !empty;
   assign doPush = push && (!full || doPop);
   assign dout   = mem[rdPtr];
   assign level  = count;

   always_ff @(posedge clk) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + AW'(1);
         if (doPop)  rdPtr <= rdPtr + AW'(1);
         case ({doPush, doPop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= din;
   end
endmodule

// File: rtl/mips_trace_capture.sv
// Captures mips_32 retire records into a FIFO and drains each as a 4-beat stream.
// Optional TRACE_FILTER_EN: keep only events with RegWrte, MemWrite, Jump or Beq set.
module mips_trace_capture
   import mips_trace_pkg::*;
#(
   parameter int         DEPTH     = 8,
   parameter logic [7:0] SYNC_WORD = DEFAULT_SYNC_WORD
) (
   input  logic                  clk,
   input  logic                  reset,
   mips_trace_capture_if.slave   bus
);
   localparam int LW = $clog2(DEPTH) + 1;

   drainState_t   state, stateNext;
   traceRecord_t  newRec, headRec;
   logic [15:0]   seqCnt, dropCnt;
   logic [7:0]    flags;
   logic [LW-1:0] fifoLevel;
   logic          fifoFull, fifoEmpty;
   logic          keep, retire, lastHs, pushOk, push, drop;
   logic [31:0]   outData;
   logic          outValid, outLast;

   assign flags = {bus.AluSource, bus.MemtoReg, bus.Jump, bus.Beq,
                   bus.Branch, bus.MemRead, bus.MemWrite, bus.RegWrte};

`ifdef TRACE_FILTER_EN
   assign keep = flags[FLAG_REGWRTE] | flags[FLAG_MEMWRITE] | flags[FLAG_JUMP] | flags[FLAG_BEQ];
`else
   assign keep = 1'b1;
`endif

   assign retire = bus.trace_en && keep;
   // The record leaving on this edge frees its slot for a simultaneous capture
   assign lastHs = (state == ALUW) && bus.out_ready;
   assign pushOk = !fifoFull || lastHs;
   assign push   = retire && pushOk;
   assign drop   = retire && !pushOk;

   assign newRec = '{seq: seqCnt, flags: flags, pc: bus.PC,
                     instr: bus.Instruction, alu: bus.ALU_Result};

   trace_fifo #(.WIDTH($bits(traceRecord_t)), .DEPTH(DEPTH)) uFifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (lastHs),
      .din   (newRec),
      .dout  (headRec),
      .full  (fifoFull),
      .empty (fifoEmpty),
      .level (fifoLevel)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         seqCnt  <= '0;
         dropCnt <= '0;
      end else begin
         state <= stateNext;
         if (retire) seqCnt <= seqCnt + 16'd1;
         if (drop && dropCnt != 16'hFFFF) dropCnt <= dropCnt + 16'd1;
      end
   end

   always_comb begin
      stateNext = state;
      outValid  = 1'b0;
      outLast   = 1'b0;
      outData   = '0;
      case (state)
         IDLE: if (!fifoEmpty) stateNext = HDR;
         HDR: begin
            outValid = 1'b1;
            outData  = {SYNC_WORD, headRec.seq, headRec.flags};
            if (bus.out_ready) stateNext = PCW;
         end
         PCW: begin
            outValid = 1'b1;
            outData  = headRec.pc;
            if (bus.out_ready) stateNext = INSW;
         end
         INSW: begin
            outValid = 1'b1;
            outData  = headRec.instr;
            if (bus.out_ready) stateNext = ALUW;
         end
         ALUW: begin
            outValid = 1'b1;
            outLast  = 1'b1;
            outData  = headRec.alu;
            if (bus.out_ready)
               stateNext = (fifoLevel > LW'(1) || push) ? HDR : IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign bus.out_data   = outData;
   assign bus.out_valid  = outValid;
   assign bus.out_last   = outLast;
   assign bus.drop_count = dropCnt;
   assign bus.fifo_level = fifoLevel;
endmodule

// File: tb/tb_mips_trace_capture.sv
// Directed bench for mips_trace_capture with an expected-beat scoreboard.
module tb_mips_trace_capture;
   localparam int DEPTH = 8;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   mips_trace_capture_if #(.DEPTH(DEPTH)) bus ();

   mips_trace_capture #(.DEPTH(DEPTH), .SYNC_WORD(8'hA5)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int          nAssert = 0;
   int          nFail   = 0;
   logic [32:0] expQ [$];
   logic [15:0] seqModel = 16'd0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp)
      else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setObs(input logic [31:0] pc, input logic [31:0] ins,
                         input logic [31:0] alu, input logic [7:0] f);
      bus.PC          = pc;
      bus.Instruction = ins;
      bus.ALU_Result  = alu;
      bus.RegWrte     = f[0];
      bus.MemWrite    = f[1];
      bus.MemRead     = f[2];
      bus.Branch      = f[3];
      bus.Beq         = f[4];
      bus.Jump        = f[5];
      bus.MemtoReg    = f[6];
      bus.AluSource   = f[7];
   endtask

   task automatic expectRec(input logic [15:0] seq, input logic [7:0] f, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] alu);
      expQ.push_back({1'b0, 8'hA5, seq, f});
      expQ.push_back({1'b0, pc});
      expQ.push_back({1'b0, ins});
      expQ.push_back({1'b1, alu});
   endtask

   // One enabled cycle; the model seq advances on every retire, kept or dropped
   task automatic capture(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] alu,
                          input logic [7:0] f, input bit expectPush);
      setObs(pc, ins, alu, f);
      bus.trace_en = 1'b1;
      if (expectPush) expectRec(seqModel, f, pc, ins, alu);
      seqModel = seqModel + 16'd1;
      tick();
      bus.trace_en = 1'b0;
   endtask

   task automatic waitValid();
      for (int i = 0; i < 20 && !bus.out_valid; i++) tick();
      check("wait_valid", {31'd0, bus.out_valid}, 32'd1);
   endtask

   task automatic waitDrain();
      for (int i = 0; i < 200 && expQ.size() != 0; i++) tick();
      check("drain_queue_empty", expQ.size(), 32'd0);
      check("idle_after_drain", {31'd0, bus.out_valid}, 32'd0);
   endtask

   task automatic doReset();
      reset = 1'b1;
      bus.trace_en = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      seqModel = 16'd0;
      expQ.delete();
   endtask

   always @(negedge clk) begin
      logic [32:0] got, want;
      if (!reset && bus.out_valid && bus.out_ready) begin
         got  = {bus.out_last, bus.out_data};
         want = (expQ.size() != 0) ? expQ.pop_front() : 33'bx;
         nAssert++;
         assert (got === want)
         else begin
            nFail++;
            $error("FAIL beat: observed last/data %h expected %h", got, want);
         end
      end
   end

   initial begin
      bus.trace_en  = 1'b0;
      bus.out_ready = 1'b0;
      setObs(32'd0, 32'd0, 32'd0, 8'h00);

      // Reset state
      doReset();
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_last", {31'd0, bus.out_last}, 32'd0);
      check("rst_out_data", bus.out_data, 32'd0);
      check("rst_fifo_level", {28'd0, bus.fifo_level}, 32'd0);
      check("rst_drop_count", {16'd0, bus.drop_count}, 32'd0);

      // Single record, sink always ready
      bus.out_ready = 1'b1;
      capture(32'h00000004, 32'h20080005, 32'h00000005, 8'h81, 1'b1);
      waitDrain();

      // Backpressure at PCW for 5 cycles
      bus.out_ready = 1'b0;
      capture(32'h00000010, 32'h8C090008, 32'h00000040, 8'h45, 1'b1);
      waitValid();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("stall_valid", {31'd0, bus.out_valid}, 32'd1);
         check("stall_data", bus.out_data, 32'h00000010);
      end
      bus.out_ready = 1'b1;
      waitDrain();

      // Overflow: 20 captures into an 8-deep FIFO with the sink stalled
      doReset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 20; i++)
         capture(32'h100 + 32'(i * 4), 32'(i), ~32'(i), 8'h01, i < DEPTH);
      tick();
      check("ovf_fifo_level", {28'd0, bus.fifo_level}, 32'd8);
      check("ovf_drop_count", {16'd0, bus.drop_count}, 32'd12);
      bus.out_ready = 1'b1;
      waitDrain();

      // Full FIFO with a capture coinciding with the ALUW handshake
      doReset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++)
         capture(32'h200 + 32'(i * 4), 32'hA000_0000 + 32'(i), 32'(i * 3), 8'h12, 1'b1);
      check("full_fifo_level", {28'd0, bus.fifo_level}, 32'd8);
      bus.out_ready = 1'b1;
      tick();
      tick();
      tick();
      check("at_aluw_last", {31'd0, bus.out_last}, 32'd1);
      capture(32'h00000300, 32'h0800_00C0, 32'h00000300, 8'h20, 1'b1);
      bus.out_ready = 1'b0;
      check("coincide_fifo_level", {28'd0, bus.fifo_level}, 32'd8);
      check("coincide_drop_count", {16'd0, bus.drop_count}, 32'd0);
      bus.out_ready = 1'b1;
      waitDrain();

      // Reset asserted while the first record is at INSW
      doReset();
      bus.out_ready = 1'b0;
      for (int i = 0; i < 10; i++)
         capture(32'h400 + 32'(i * 4), 32'hB000_0000 + 32'(i), 32'(i), 8'h03, 1'b0);
      expQ.push_back({1'b0, 8'hA5, 16'h0000, 8'h03});
      expQ.push_back({1'b0, 32'h00000400});
      bus.out_ready = 1'b1;
      tick();
      tick();
      bus.out_ready = 1'b0;
      check("insw_data", bus.out_data, 32'hB000_0000);
      check("pre_rst_drop_count", {16'd0, bus.drop_count}, 32'd2);
      reset = 1'b1;
      tick();
      check("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("midrst_fifo_level", {28'd0, bus.fifo_level}, 32'd0);
      check("midrst_drop_count", {16'd0, bus.drop_count}, 32'd0);
      check("midrst_out_data", bus.out_data, 32'd0);
      check("midrst_beats_seen", expQ.size(), 32'd0);
      reset = 1'b0;
      seqModel = 16'd0;
      bus.out_ready = 1'b1;
      capture(32'h00000500, 32'h2108_0001, 32'h00000006, 8'h81, 1'b1);
      waitDrain();

      // Alternating strobe patterns; only kept events consume a seq value when filtering
      doReset();
      bus.out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
`ifdef TRACE_FILTER_EN
         capture(32'h600 + 32'(i * 4), 32'(i), 32'(i + 1), (i % 2 == 0) ? 8'h01 : 8'h00, i % 2 == 0);
         if (i % 2 != 0) seqModel = seqModel - 16'd1;
`else
         capture(32'h600 + 32'(i * 4), 32'(i), 32'(i + 1), (i % 2 == 0) ? 8'h01 : 8'h00, 1'b1);
`endif
      end
      waitDrain();
      check("alt_drop_count", {16'd0, bus.drop_count}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end
endmodule

// File: doc/mips_trace_capture.md
Name: mips_trace_capture

Overview:
- Consumer of the mips_32 observation port (PC, Instruction, ALU_Result, control strobes).
- Samples one retire record per clock while tracing is enabled and buffers the records in a FIFO.
- Drains each record as a 4-beat 32-bit valid/ready stream, for a trace sink or a host-side logger.
- Counts records lost to FIFO overflow, so the on-chip equivalent of the bench's observation role is the receiving end of the processor's debug outputs.

Parameters:
- DEPTH, 8, FIFO depth in records; power of two, minimum 2.
- SYNC_WORD, 8'hA5, marker placed in header bits [31:24].

Ports:
- clk  in  1  rising-edge clock shared with mips_32.
- reset  in  1  synchronous, active-high.
- trace_en  in  1  capture enable.
- PC  in  32  processor program counter.
- Instruction  in  32  current instruction word.
- ALU_Result  in  32  ALU output.
- RegWrte, MemWrite, MemRead, Branch, Beq, Jump, MemtoReg, AluSource  in  1 each  processor control strobes.
- out_data  out  32  stream beat.
- out_valid  out  1  beat available.
- out_ready  in  1  sink accepts beat.
- out_last  out  1  final beat of a record.
- drop_count  out  16  records lost to overflow.
- fifo_level  out  $clog2(DEPTH)+1  records held.

Behaviour:
- Capture condition: every rising edge with reset=0 and trace_en=1 produces one retire event.
- Flags byte [7:0] is {AluSource, MemtoReg, Jump, Beq, Branch, MemRead, MemWrite, RegWrte}.
- Each retire event forms a record {seq[15:0], flags, PC, Instruction, ALU_Result}.
- seq is a 16-bit counter. It increments on every retire event, including dropped ones, and wraps FFFF->0000. Gaps in seq at the sink reveal drops.
- Push occurs if the FIFO is not full, or if the record currently draining completes (last beat handshake) in the same cycle. Otherwise the record is dropped and drop_count increments, saturating at FFFF.
- Drain FSM states are IDLE, HDR, PCW, INSW, ALUW.
  - IDLE -> HDR when the FIFO is non-empty.
  - Each state advances on out_valid && out_ready.
  - ALUW -> HDR if the FIFO is still non-empty after pop, else -> IDLE.
- Beat contents:
  - HDR = {SYNC_WORD, seq, flags}.
  - PCW = PC.
  - INSW = Instruction.
  - ALUW = ALU_Result, with out_last=1.
- The record is popped on the ALUW handshake.
- out_valid=1 in HDR/PCW/INSW/ALUW. out_data and out_last hold stable while out_valid && !out_ready.
- Latency: a record captured at edge N is presented as HDR no earlier than the cycle after edge N (valid after N+1 when the FIFO was empty and the FSM was IDLE).
- Full throughput is one record per 4 cycles. A sustained one-per-cycle capture rate overflows the FIFO by design, and drop_count reports the loss.
- Reset: out_valid=0, out_last=0, out_data=0, drop_count=0, fifo_level=0, seq=0, FSM=IDLE, FIFO pointers cleared. Reset mid-record abandons the record with no further beats.
- trace_en deassert mid-drain: draining continues and only new capture stops.

Optional Feature:
- Macro: TRACE_FILTER_EN.
- Defined: a retire event is pushed only if any of RegWrte, MemWrite, Jump or Beq is 1. Filtered events do not increment seq and do not count as drops.
- Undefined: every enabled cycle is captured.

Decomposition:
- Package mips_trace_pkg:
  - FSM state enum.
  - Flag bit index constants.
  - Beat count (4).
  - Default SYNC_WORD.
  - Record struct {seq, flags, pc, instr, alu} of width 120.
- Sub-module trace_fifo: synchronous single-clock FIFO, parameterised on width and depth, with a push/pop same-cycle-when-full rule and a level output.
- FSM, seq counter and drop counter live in the top module.

Test Plan:
- Reset release, trace_en=1 for 1 cycle with PC=0x00000004, Instruction=0x20080005, ALU_Result=5, RegWrte=1, AluSource=1, out_ready=1 -> beats A5_0000_81, 00000004, 20080005, 00000005, with out_last only on beat 4.
- out_ready=0 for 5 cycles mid-record (at PCW) -> out_data holds 00000004 and out_valid stays 1, then the remaining beats follow in order.
- DEPTH=8, trace_en=1 for 20 cycles, out_ready=0 -> fifo_level=8, drop_count=12; after draining, header seq values are 0..7.
- FIFO full and the ALUW handshake coinciding with a new capture -> record accepted, fifo_level unchanged, drop_count unchanged.
- reset asserted during INSW -> next cycle out_valid=0, fifo_level=0, drop_count=0; the next capture carries seq=0000.
- TRACE_FILTER_EN defined, alternating cycles of RegWrte=1 and all strobes 0 -> only RegWrte records appear, with consecutive seq values 0,1,2.
